lifo_unloader: RTL
==================

LIFO_UNLOADER -- requirements
Module: lifo_unloader

Interface
REQ-001 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port Rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port wrReq  input  1  producer push request, sampled each Clk edge.
REQ-004 SHALL have port wrData  input  4  producer nibble, valid with wrReq.
REQ-005 SHALL have port wrBusy  output  1  high when pushes are not accepted.
REQ-006 SHALL have port wrDrop  output  1  sticky flag: a wrReq arrived while wrBusy=1.
REQ-007 SHALL have port lifoEN  output  1  drives stack EN.
REQ-008 SHALL have port lifoRW  output  1  drives stack RW (0 = push, 1 = pop).
REQ-009 SHALL have port lifoRst  output  1  drives stack Rst (active-high, synchronous, gated by EN).
REQ-010 SHALL have port lifoDataIn  output  4  drives stack dataIn.
REQ-011 SHALL have port lifoDataOut  input  4  stack dataOut; valid in the cycle after a pop edge.
REQ-012 SHALL have port wordOut  output  16  assembled word, registered.
REQ-013 SHALL have port wordValid  output  1  wordOut holds a complete word.
REQ-014 SHALL have port wordReady  input  1  consumer accepts wordOut.

Function
REQ-015 SHALL implement FSM states INIT, FILL, DRAIN, HOLD; plus a 3-bit occupancy count cnt (0..4) and a 3-bit phase counter ph (0..4).
REQ-016 INIT: lifoEN=1, lifoRst=1, wrBusy=1 for exactly one cycle; next state FILL with cnt=0.
REQ-017 FILL: wrBusy=0; when wrReq=1, lifoEN=1, lifoRW=0, lifoRst=0, lifoDataIn=wrData combinationally in the same cycle; cnt increments at that edge.
REQ-018 FILL: when wrReq=0, lifoEN=0 (the stack is not clocked, so no spurious push occurs).
REQ-019 FILL -> DRAIN at the edge where cnt becomes 4; ph cleared to 0.
REQ-020 DRAIN: lifoEN=1, lifoRW=1, lifoRst=0 while ph<4 (four consecutive pop edges); lifoEN=0 at ph=4; ph increments every cycle.
REQ-021 DRAIN: at each edge with ph in 1..4, wordOut <= {wordOut[11:0], lifoDataOut}; the first popped nibble (last pushed) ends in wordOut[15:12].
REQ-022 DRAIN -> HOLD at the edge where ph=4; wordValid rises at that edge; cnt <= 0.
REQ-023 HOLD: lifoEN=0; wordOut and wordValid stable until wordValid&&wordReady at an edge; then wordValid <= 0 and next state FILL.
REQ-024 Latency: 5 cycles from the edge that makes cnt=4 to wordValid=1.
REQ-025 wrBusy SHALL be 1 in INIT, DRAIN and HOLD; wrReq in those states is dropped and sets wrDrop at that edge.
REQ-026 wrReq and wordReady together in HOLD: word accepted, push dropped, wrDrop set; the first accepted push occurs in the next cycle (FILL).
REQ-027 wordReady while wordValid=0 SHALL have no effect.
REQ-028 cnt SHALL never exceed 4 and the block SHALL never issue a push at cnt=4 or a pop at cnt=0 (the stack FULL/EMPTY flags are not relied upon).

Reset
REQ-029 Rst_n=0 SHALL immediately force state=INIT, cnt=0, ph=0, wordOut=16'h0000, wordValid=0, wrDrop=0, independent of Clk.
REQ-030 While Rst_n=0, outputs SHALL be lifoEN=0, lifoRst=1, wrBusy=1; INIT (REQ-016) runs on the first edge after release.
REQ-031 Reset asserted mid-FILL or mid-DRAIN SHALL discard partial data; the stack is re-cleared by INIT.

Verification
REQ-032 Reset release, push 1,2,3,4 on consecutive cycles, wordReady=1 -> wordOut=16'h4321, wordValid high 5 cycles after the 4th push edge, returns to FILL.
REQ-033 Push A,B with 3 idle cycles between, then C,D -> no lifoEN pulse in idle cycles; wordOut=16'hDCBA.
REQ-034 wordReady=0 for 10 cycles in HOLD -> wordOut and wordValid stable; wrReq pulses there set wrDrop=1 and do not change cnt.
REQ-035 Rst_n pulled low at DRAIN ph=2 -> wordValid=0, wordOut=0 at once; after release, INIT pulse, then fresh push 5,6,7,8 yields 16'h8765.
REQ-036 Back-to-back: two full 4-push batches with wordReady held high -> words 16'h4321 then 16'h8765, no lost or duplicated nibble, wrDrop=0.

Source files
------------

// File: rtl/lifo_unloader.sv
// Packs four nibbles pushed through an external 4-deep stack into a 16-bit word, last pushed nibble in the top position.
// Latency: wordValid rises 5 cycles after the edge that stores the 4th nibble.
// Backpressure: wrBusy is high outside FILL and such pushes only set wrDrop; a finished word is held until wordReady.
module lifo_unloader (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        wrReq,
  input  logic [3:0]  wrData,
  output logic        wrBusy,
  output logic        wrDrop,
  output logic        lifoEN,
  output logic        lifoRW,
  output logic        lifoRst,
  output logic [3:0]  lifoDataIn,
  input  logic [3:0]  lifoDataOut,
  output logic [15:0] wordOut,
  output logic        wordValid,
  input  logic        wordReady
);

  localparam logic [1:0] INIT  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [1:0] state;
  logic [2:0] cnt;
  logic [2:0] ph;

  // While in reset the stack is left unclocked; INIT clears it once reset is released.
  always_comb begin
    lifoEN     = 1'b0;
    lifoRW     = 1'b0;
    lifoRst    = 1'b0;
    wrBusy     = 1'b1;
    lifoDataIn = wrData;
    if (!Rst_n) begin
      lifoRst = 1'b1;
    end else begin
      case (state)
        INIT: begin
          lifoEN  = 1'b1;
          lifoRst = 1'b1;
        end
        FILL: begin
          wrBusy = 1'b0;
          lifoEN = wrReq && (cnt < 3'd4);
        end
        DRAIN: begin
          lifoEN = (ph < 3'd4);
          lifoRW = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= INIT;
      cnt       <= 3'd0;
      ph        <= 3'd0;
      wordOut   <= 16'h0000;
      wordValid <= 1'b0;
      wrDrop    <= 1'b0;
    end else begin
      if (wrReq && wrBusy)
        wrDrop <= 1'b1;
      case (state)
        INIT: begin
          state <= FILL;
          cnt   <= 3'd0;
          ph    <= 3'd0;
        end
        FILL: begin
          if (wrReq && (cnt < 3'd4)) begin
            cnt <= cnt + 3'd1;
            if (cnt == 3'd3) begin
              state <= DRAIN;
              ph    <= 3'd0;
            end
          end
        end
        DRAIN: begin
          // Popped data appears one cycle after its pop edge, hence shift at ph 1..4.
          if (ph != 3'd0)
            wordOut <= {wordOut[11:0], lifoDataOut};
          if (ph == 3'd4) begin
            state     <= HOLD;
            wordValid <= 1'b1;
            cnt       <= 3'd0;
            ph        <= 3'd0;
          end else begin
            ph <= ph + 3'd1;
          end
        end
        HOLD: begin
          if (wordValid && wordReady) begin
            wordValid <= 1'b0;
            state     <= FILL;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule
